ecc_mul_arbiter: RTL and testbench

- Shares one registered 5-limb partial-product multiplier stage between NREQ requesters, e.g. the point-add unit and the inversion/division unit.
- Arbitrates operand pairs round-robin, registers the selected operands onto the datapath and tracks in-flight operations through the datapath latency.
- Captures each 9-limb partial-product result into a per-requester response buffer with valid/ready return.
- Sits between the ECC arithmetic controllers and the multiplier datapath.

---
 rtl/ecc_mul_pkg.sv | 22 ++
 rtl/ecc_mul_arbiter_if.sv | 24 ++
 rtl/ecc_mul_arbiter_rr_arbiter.sv | 30 +++
 rtl/ecc_mul_arbiter.sv | 116 +++++++++++
 tb/tb_ecc_mul_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_mul_pkg.sv
// Shared widths and types for the ECC multiplier sharing logic.
// Limb geometry is fixed here so requesters, arbiter and datapath agree.
package ecc_mul_pkg;

   localparam int LIMBS     = 5;
   localparam int LW        = 8;
   localparam int NLIMB_OUT = 2*LIMBS-1;
   localparam int OPW       = LIMBS*LW;
   localparam int RESW      = NLIMB_OUT*LW;
   localparam int MAX_NREQ  = 4;
   localparam int IDW       = $clog2(MAX_NREQ);

   typedef logic [OPW-1:0]  operand_t;
   typedef logic [RESW-1:0] result_t;

   // One slot of the in-flight tracker; id is sized for the largest requester count.
   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
   } pipe_entry_t;

endpackage

// File: rtl/ecc_mul_arbiter_if.sv
// Requester-side request/response bundle of the shared multiplier.
// master = the arithmetic controllers, slave = the arbiter.
interface ecc_mul_arbiter_if #(parameter int NREQ = 2);
   import ecc_mul_pkg::*;

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*OPW-1:0]  req_a;
   logic [NREQ*OPW-1:0]  req_b;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [NREQ*RESW-1:0] rsp_s;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_s
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_s
   );

endinterface

// File: rtl/ecc_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above ptr, wrapping.
// Reusable by any controller that shares a single resource.
module rr_arbiter #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   always_comb begin
      logic [IW-1:0] sel;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      sel       = '0;
      for (int off = 0; off < N; off++) begin
         sel = IW'((int'(ptr) + off) % N);
         if (!any && eligible[sel]) begin
            grant[sel] = 1'b1;
            grant_idx  = sel;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ecc_mul_arbiter.sv
// Shares one registered partial-product multiplier stage between NREQ requesters,
// tracking in-flight operations and buffering each result per requester.
module ecc_mul_arbiter
   import ecc_mul_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int LAT  = 1
) (
   input  logic     clk,
   input  logic     reset,
   ecc_mul_arbiter_if.slave bus,
   output operand_t dp_a,
   output operand_t dp_b,
   input  result_t  dp_s,
   output logic     busy
);

   localparam int PW = $clog2(NREQ);

   logic [NREQ-1:0]      pending_q, pending_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   operand_t             dp_a_q, dp_a_d;
   operand_t             dp_b_q, dp_b_d;
   logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [NREQ*RESW-1:0] rsp_s_q, rsp_s_d;
   pipe_entry_t          pipe_q [LAT+1];
   pipe_entry_t          pipe_d [LAT+1];

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic            grant_any;

   // A requester with an unconsumed result stays out of arbitration, which also
   // keeps rsp_ready off the req_ready path.
   assign eligible = bus.req_valid & ~pending_q;

   rr_arbiter #(.N(NREQ)) u_rr (
      .eligible  (eligible),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (grant_any)
   );

   always_comb begin
      pending_d   = pending_q;
      rr_ptr_d    = rr_ptr_q;
      dp_a_d      = dp_a_q;
      dp_b_d      = dp_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_s_d     = rsp_s_q;

      pipe_d[0].valid = grant_any;
      pipe_d[0].id    = IDW'(grant_idx);
      for (int k = 1; k <= LAT; k++) begin
         pipe_d[k] = pipe_q[k-1];
      end

      if (grant_any) begin
         rr_ptr_d  = PW'((int'(grant_idx) + 1) % NREQ);
         pending_d = pending_q | grant;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            dp_a_d = bus.req_a[i*OPW +: OPW];
            dp_b_d = bus.req_b[i*OPW +: OPW];
         end
      end

      for (int i = 0; i < NREQ; i++) begin
         if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
            pending_d[i]   = 1'b0;
         end
      end

      // The entry leaving the last stage is the one whose result dp_s now holds.
      for (int i = 0; i < NREQ; i++) begin
         if (pipe_q[LAT].valid && pipe_q[LAT].id == IDW'(i)) begin
            rsp_valid_d[i]              = 1'b1;
            rsp_s_d[i*RESW +: RESW]     = dp_s;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= '0;
         rr_ptr_q    <= '0;
         dp_a_q      <= '0;
         dp_b_q      <= '0;
         rsp_valid_q <= '0;
         rsp_s_q     <= '0;
         for (int k = 0; k <= LAT; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         pending_q   <= pending_d;
         rr_ptr_q    <= rr_ptr_d;
         dp_a_q      <= dp_a_d;
         dp_b_q      <= dp_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_s_q     <= rsp_s_d;
         pipe_q      <= pipe_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_s     = rsp_s_q;
   assign dp_a          = dp_a_q;
   assign dp_b          = dp_b_q;
   assign busy          = |pending_q;

endmodule

// File: tb/tb_ecc_mul_arbiter.sv
// Directed bench for ecc_mul_arbiter with a one-cycle partial-product datapath model
// (per column, sum of bitwise limb products, wrapping at 8 bits).
module tb_ecc_mul_arbiter;
   import ecc_mul_pkg::*;

   logic     clk;
   logic     reset;
   operand_t dp_a;
   operand_t dp_b;
   result_t  dp_s;
   logic     busy;
   int       errors = 0;
   int       checks = 0;

   ecc_mul_arbiter_if #(.NREQ(2)) bus ();

   ecc_mul_arbiter #(.NREQ(2), .LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .dp_a  (dp_a),
      .dp_b  (dp_b),
      .dp_s  (dp_s),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic result_t pp_model(operand_t a, operand_t b);
      result_t r;
      r = '0;
      for (int i = 0; i < LIMBS; i++) begin
         for (int j = 0; j < LIMBS; j++) begin
            r[(i+j)*LW +: LW] = r[(i+j)*LW +: LW] + (a[i*LW +: LW] & b[j*LW +: LW]);
         end
      end
      return r;
   endfunction

   always @(posedge clk) dp_s <= pp_model(dp_a, dp_b);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
      checks++; if (bus.rsp_s !== '0) begin errors++; $display("[TB] FAIL reset_rsp_s: got %h expected 0", bus.rsp_s); end
      checks++; if (dp_a !== '0) begin errors++; $display("[TB] FAIL reset_dp_a: got %h expected 0", dp_a); end
      checks++; if (dp_b !== '0) begin errors++; $display("[TB] FAIL reset_dp_b: got %h expected 0", dp_b); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_ready [8];
      logic [1:0] exp_rv [8];
      exp_ready = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
      exp_rv    = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
      bus.req_a[39:0]  = 40'hFF_FF_FF_FF_FF;
      bus.req_b[39:0]  = 40'h01_01_01_01_01;
      bus.req_a[79:40] = 40'h00_00_00_03_0F;
      bus.req_b[79:40] = 40'h00_00_00_01_F0;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++; if (bus.req_ready !== exp_ready[c]) begin errors++; $display("[TB] FAIL contention_grant c%0d: got %b expected %b", c, bus.req_ready, exp_ready[c]); end
         checks++; if (bus.rsp_valid !== exp_rv[c]) begin errors++; $display("[TB] FAIL contention_rsp_valid c%0d: got %b expected %b", c, bus.rsp_valid, exp_rv[c]); end
         if (c == 4) begin
            checks++; if (bus.rsp_s[71:0] !== 72'h01_02_03_04_05_04_03_02_01) begin errors++; $display("[TB] FAIL contention_rsp_s0: got %h expected 010203040504030201", bus.rsp_s[71:0]); end
         end
         if (c == 5) begin
            checks++; if (bus.rsp_s[143:72] !== 72'h00_00_00_00_00_00_01_01_00) begin errors++; $display("[TB] FAIL contention_rsp_s1: got %h expected 000000000000010100", bus.rsp_s[143:72]); end
         end
         tick();
      end
      bus.req_valid = 2'b00;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL contention_drain_busy: got %b expected 0", busy); end
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL contention_drain_rsp_valid: got %b expected 00", bus.rsp_valid); end
      bus.rsp_ready = 2'b00;
   endtask

   task automatic test_single();
      bus.req_a[39:0] = 40'hFF_FF_FF_FF_FF;
      bus.req_b[39:0] = 40'h01_01_01_01_01;
      bus.req_valid   = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_grant: got %b expected 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      checks++; if (dp_a !== 40'hFF_FF_FF_FF_FF) begin errors++; $display("[TB] FAIL single_dp_a: got %h expected ffffffffff", dp_a); end
      checks++; if (dp_b !== 40'h01_01_01_01_01) begin errors++; $display("[TB] FAIL single_dp_b: got %h expected 0101010101", dp_b); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_inflight: got %b expected 1", busy); end
      tick();
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_early_rsp: got %b expected 00", bus.rsp_valid); end
      tick();
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL single_rsp_valid: got %b expected 01", bus.rsp_valid); end
      checks++; if (bus.rsp_s[71:0] !== 72'h01_02_03_04_05_04_03_02_01) begin errors++; $display("[TB] FAIL single_rsp_s0: got %h expected 010203040504030201", bus.rsp_s[71:0]); end
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_rsp_consumed: got %b expected 00", bus.rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_idle: got %b expected 0", busy); end
      checks++; if (bus.rsp_s[71:0] !== 72'h01_02_03_04_05_04_03_02_01) begin errors++; $display("[TB] FAIL single_rsp_hold: got %h expected 010203040504030201", bus.rsp_s[71:0]); end
   endtask

   task automatic test_backpressure();
      bus.req_a[39:0] = 40'h00_00_00_00_55;
      bus.req_b[39:0] = 40'h00_00_00_00_0F;
      bus.req_valid   = 2'b01;
      bus.rsp_ready   = 2'b10;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL bp_first_grant: got %b expected 01", bus.req_ready); end
      tick();
      for (int c = 1; c < 3; c++) begin
         checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_pending_block c%0d: got %b expected 00", c, bus.req_ready); end
         tick();
      end
      bus.req_a[79:40] = 40'hFF_FF_FF_FF_FF;
      bus.req_b[79:40] = 40'h01_01_01_01_01;
      bus.req_valid    = 2'b11;
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL bp_other_grant: got %b expected 10", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL bp_rsp_held: got %b expected 01", bus.rsp_valid); end
      checks++; if (bus.rsp_s[71:0] !== 72'h05) begin errors++; $display("[TB] FAIL bp_rsp_s0: got %h expected 05", bus.rsp_s[71:0]); end
      tick();
      bus.req_valid = 2'b01;
      for (int c = 4; c < 6; c++) begin
         checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_stalled_grant c%0d: got %b expected 00", c, bus.req_ready); end
         tick();
      end
      checks++; if (bus.rsp_valid !== 2'b11) begin errors++; $display("[TB] FAIL bp_both_rsp: got %b expected 11", bus.rsp_valid); end
      tick();
      bus.rsp_ready = 2'b11;
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_same_cycle_grant: got %b expected 00", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL bp_rsp_before_pulse: got %b expected 01", bus.rsp_valid); end
      tick();
      bus.rsp_ready   = 2'b10;
      bus.req_a[39:0] = 40'h00_00_00_00_33;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL bp_regrant: got %b expected 01", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL bp_rsp_cleared: got %b expected 00", bus.rsp_valid); end
      tick();
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b11;
      tick();
      tick();
      checks++; if (bus.rsp_s[71:0] !== 72'h03) begin errors++; $display("[TB] FAIL bp_second_rsp_s0: got %h expected 03", bus.rsp_s[71:0]); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_busy_idle: got %b expected 0", busy); end
      bus.rsp_ready = 2'b00;
   endtask

   task automatic test_back_to_back();
      bus.req_a[39:0]  = 40'h00_00_00_00_12;
      bus.req_b[39:0]  = 40'h00_00_00_00_FF;
      bus.req_a[79:40] = 40'h80_00_00_00_34;
      bus.req_b[79:40] = 40'h80_00_00_00_FF;
      bus.req_valid    = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL b2b_grant0: got %b expected 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b10;
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL b2b_grant1: got %b expected 10", bus.req_ready); end
      checks++; if (dp_a !== 40'h00_00_00_00_12) begin errors++; $display("[TB] FAIL b2b_dp_a0: got %h expected 0000000012", dp_a); end
      tick();
      bus.req_valid = 2'b00;
      checks++; if (dp_a !== 40'h80_00_00_00_34) begin errors++; $display("[TB] FAIL b2b_dp_a1: got %h expected 8000000034", dp_a); end
      tick();
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL b2b_rsp_first: got %b expected 01", bus.rsp_valid); end
      checks++; if (bus.rsp_s[71:0] !== 72'h12) begin errors++; $display("[TB] FAIL b2b_rsp_s0: got %h expected 12", bus.rsp_s[71:0]); end
      tick();
      checks++; if (bus.rsp_valid !== 2'b11) begin errors++; $display("[TB] FAIL b2b_rsp_both: got %b expected 11", bus.rsp_valid); end
      checks++; if (bus.rsp_s[143:72] !== 72'h80_00_00_00_80_00_00_00_34) begin errors++; $display("[TB] FAIL b2b_rsp_s1: got %h expected 800000008000000034", bus.rsp_s[143:72]); end
      checks++; if (bus.rsp_s[71:0] !== 72'h12) begin errors++; $display("[TB] FAIL b2b_rsp_s0_kept: got %h expected 12", bus.rsp_s[71:0]); end
      bus.rsp_ready = 2'b01;
      tick();
      checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL b2b_rsp_after_pop0: got %b expected 10", bus.rsp_valid); end
      checks++; if (bus.rsp_s[143:72] !== 72'h80_00_00_00_80_00_00_00_34) begin errors++; $display("[TB] FAIL b2b_rsp_s1_hold: got %h expected 800000008000000034", bus.rsp_s[143:72]); end
      bus.rsp_ready = 2'b10;
      tick();
      bus.rsp_ready = 2'b00;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_idle: got %b expected 0", busy); end
   endtask

   task automatic test_wrap();
      bus.req_a[39:0] = 40'hFF_FF_FF_FF_FF;
      bus.req_b[39:0] = 40'hFF_FF_FF_FF_FF;
      bus.req_valid   = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL wrap_grant: got %b expected 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      tick();
      tick();
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL wrap_rsp_valid: got %b expected 01", bus.rsp_valid); end
      checks++; if (bus.rsp_s[39:32] !== 8'hFB) begin errors++; $display("[TB] FAIL wrap_s4: got %h expected fb", bus.rsp_s[39:32]); end
      checks++; if (bus.rsp_s[7:0] !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_s0: got %h expected ff", bus.rsp_s[7:0]); end
      checks++; if (bus.rsp_s[71:0] !== 72'hFF_FE_FD_FC_FB_FC_FD_FE_FF) begin errors++; $display("[TB] FAIL wrap_rsp_s0: got %h expected fffefdfcfbfcfdfeff", bus.rsp_s[71:0]); end
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;
   endtask

   task automatic test_reset_midflight();
      bus.req_a[39:0] = 40'h01_02_03_04_05;
      bus.req_b[39:0] = 40'hFF_FF_FF_FF_FF;
      bus.req_valid   = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL midrst_grant: got %b expected 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      reset         = 1'b1;
      tick();
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL midrst_rsp_valid: got %b expected 00", bus.rsp_valid); end
      checks++; if (bus.rsp_s !== '0) begin errors++; $display("[TB] FAIL midrst_rsp_s: got %h expected 0", bus.rsp_s); end
      checks++; if (dp_a !== '0) begin errors++; $display("[TB] FAIL midrst_dp_a: got %h expected 0", dp_a); end
      checks++; if (dp_b !== '0) begin errors++; $display("[TB] FAIL midrst_dp_b: got %h expected 0", dp_b); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL midrst_req_ready: got %b expected 00", bus.req_ready); end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL midrst_ghost_rsp c%0d: got %b expected 00", c, bus.rsp_valid); end
         tick();
      end
      bus.req_valid = 2'b11;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL midrst_first_grant: got %b expected 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b11;
      repeat (3) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_drain_busy: got %b expected 0", busy); end
      bus.rsp_ready = 2'b00;
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      tick();
      test_contention();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
